apb4_gpio_irq: RTL
==================

APB4_GPIO_IRQ -- requirements
Module: apb4_gpio_irq

Interface
REQ-001 SHALL have parameter PDATA_SIZE, default 8, meaning the GPIO and APB data width (8, 16 or 32).
REQ-002 SHALL have parameter PADDR_SIZE, default 8, meaning the APB address width (minimum 6).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning the input synchroniser depth (2 or 3).
REQ-004 PCLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 PRESET  in  1  reset, asynchronous and active-high.
REQ-006 PSEL, PENABLE, PWRITE  in  1 each  APB4 control.
REQ-007 PADDR  in  PADDR_SIZE  byte address; only PADDR[5:2] is decoded.
REQ-008 PWDATA  in  PDATA_SIZE; PSTRB  in  PDATA_SIZE/8  write data and byte strobes.
REQ-009 PRDATA  out  PDATA_SIZE; PREADY  out  1; PSLVERR  out  1  APB4 response.
REQ-010 gpio_i  in  PDATA_SIZE  asynchronous pins; gpio_o, gpio_oe  out  PDATA_SIZE  pin drive and enable.
REQ-011 irq_o  out  1  registered interrupt to the core IRQ vector.

Function
REQ-012 Register map (word offsets): 0x00 DIR rw; 0x04 OUT rw; 0x08 IN ro; 0x0C IE rw; 0x10 ITYPE rw (0 level, 1 edge); 0x14 IPOL rw (level: 1 high-active; edge: 1 rising); 0x18 IBOTH rw (edge on both transitions, overrides IPOL); 0x1C OUTSET wo; 0x20 OUTCLR wo; 0x24 ISTAT r/w1c.
REQ-013 PREADY SHALL be constant 1 (zero wait states); a write commits on the edge where PSEL&PENABLE&PWRITE.
REQ-014 Each write honours PSTRB per byte lane; unstrobed lanes hold their value.
REQ-015 PSLVERR SHALL be 1 during the access phase for offsets above 0x24 or writes to IN; such writes change no state.
REQ-016 PRDATA SHALL show the addressed register during PSEL&PENABLE&!PWRITE and 0 otherwise; OUTSET/OUTCLR read 0.
REQ-017 OUTSET write: OUT |= strobed data; OUTCLR write: OUT &= ~strobed data.
REQ-018 gpio_oe = DIR, gpio_o = OUT; both are direct register outputs.
REQ-019 gpio_i SHALL pass through SYNC_STAGES flops; IN is the last stage; a previous-value register of the last stage feeds edge detection.
REQ-020 Warm-up: a counter SHALL suppress edge latching for SYNC_STAGES+1 cycles after reset release.
REQ-021 Edge mode: the ISTAT bit sets on the selected transition of IN and stays set until cleared by writing 1.
REQ-022 Level mode: the ISTAT bit equals (IN == IPOL) each cycle; w1c has no effect.
REQ-023 Same-cycle w1c clear and new edge on one bit: the set SHALL win.
REQ-024 Writes to ITYPE, IPOL or IBOTH SHALL not modify latched edge bits.
REQ-025 irq_o SHALL register |(ISTAT & IE); pin transition to irq_o = SYNC_STAGES+2 rising edges after the first sampling edge.

Reset
REQ-026 On PRESET: DIR, OUT, IE, ITYPE, IPOL, IBOTH, ISTAT, synchroniser and previous-value flops, warm-up counter and irq_o = 0; gpio_o = gpio_oe = 0; PRDATA = 0, PSLVERR = 0, PREADY = 1.
REQ-027 Reset asserted mid-transfer SHALL abort it with no register update; reset asserted with irq_o = 1 SHALL drop irq_o immediately.

Verification
REQ-028 Write DIR=0xFF, OUT=0xA5 (PSTRB=1) -> gpio_oe=0xFF, gpio_o=0xA5; OUTSET 0x0A -> 0xAF; OUTCLR 0x81 -> 0x2E.
REQ-029 ITYPE=0x01, IPOL=0x01, IE=0x01; gpio_i[0] 0->1 -> ISTAT=0x01, irq_o=1 exactly 4 edges later (SYNC_STAGES=2); w1c 0x01 -> irq_o=0 one cycle after.
REQ-030 Level mode, IPOL=0, IE=0x04, gpio_i[2]=0 -> irq_o=1; w1c 0x04 -> stays 1; gpio_i[2]=1 -> irq_o=0 after 4 edges.
REQ-031 IBOTH=0x02, edge mode: gpio_i[1] toggles, w1c 0x02 issued on the set cycle of the second edge -> ISTAT[1] remains 1.
REQ-032 Read 0x28 -> PSLVERR=1, PRDATA=0; write IN -> PSLVERR=1, IN unchanged; gpio_i=0xFF held through reset release -> ISTAT stays 0 (warm-up).
REQ-033 PRESET pulsed during access phase of OUT write 0x55 -> OUT=0x00, gpio_o=0x00, irq_o=0 asynchronously.

Source files
------------

// File: rtl/apb4_gpio_irq.sv
`default_nettype none
// ============================================================================
// Module   : apb4_gpio_irq
// Purpose  : APB4 slave GPIO block with per-pin direction, output set/clear,
//            synchronised inputs and a level/edge interrupt controller.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   PCLK, PRESET           clock, asynchronous active-high reset
//   PSEL/PENABLE/PWRITE    APB4 control
//   PADDR                  byte address (bits [5:2] select the register)
//   PWDATA, PSTRB          write data and byte-lane strobes
//   PRDATA/PREADY/PSLVERR  APB4 response (zero wait states)
//   gpio_i                 asynchronous input pins
//   gpio_o, gpio_oe        pin drive value and output enable
//   irq_o                  registered interrupt request
// ============================================================================
module apb4_gpio_irq #(
  parameter int PDATA_SIZE  = 8,
  parameter int PADDR_SIZE  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [PADDR_SIZE-1:0]   PADDR,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic [PDATA_SIZE-1:0]   gpio_i,
  output logic [PDATA_SIZE-1:0]   gpio_o,
  output logic [PDATA_SIZE-1:0]   gpio_oe,
  output logic                    irq_o
);

  // Register word indices (PADDR[5:2])
  localparam logic [3:0] R_DIR    = 4'd0;
  localparam logic [3:0] R_OUT    = 4'd1;
  localparam logic [3:0] R_IN     = 4'd2;
  localparam logic [3:0] R_IE     = 4'd3;
  localparam logic [3:0] R_ITYPE  = 4'd4;
  localparam logic [3:0] R_IPOL   = 4'd5;
  localparam logic [3:0] R_IBOTH  = 4'd6;
  localparam logic [3:0] R_OUTSET = 4'd7;
  localparam logic [3:0] R_OUTCLR = 4'd8;
  localparam logic [3:0] R_ISTAT  = 4'd9;

  // Warm-up counter must reach SYNC_STAGES+1
  localparam int              WARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

  logic [PDATA_SIZE-1:0] dir_q, out_q, ie_q, itype_q, ipol_q, iboth_q;
  logic [PDATA_SIZE-1:0] istat_q, istat_d;
  logic [PDATA_SIZE-1:0] prev_q;
  logic [SYNC_STAGES-1:0][PDATA_SIZE-1:0] sync_q;
  logic [WARM_W-1:0]     warm_q;
  logic                  irq_q;

  logic [3:0]            idx;
  logic                  access, bad_addr, err, wr_en, warm_done;
  logic [PDATA_SIZE-1:0] strb_mask, wmask, in_w;
  logic [PDATA_SIZE-1:0] rise, fall, edge_hit, level, w1c;
  logic                  unused_addr_bits;

  assign idx       = PADDR[5:2];
  assign access    = PSEL & PENABLE;
  assign bad_addr  = (idx > R_ISTAT);
  assign err       = access & (bad_addr | (PWRITE & (idx == R_IN)));
  assign wr_en     = access & PWRITE & ~err;
  assign warm_done = (warm_q == WARM_DONE);
  // Only PADDR[5:2] is decoded; fold the rest so nothing dangles
  assign unused_addr_bits = &{1'b0, PADDR};

  // Expand byte strobes into a bit mask
  for (genvar i = 0; i < PDATA_SIZE / 8; i++) begin : g_lane
    assign strb_mask[8*i +: 8] = {8{PSTRB[i]}};
  end
  assign wmask = PWDATA & strb_mask;

  // Interrupt status next-state
  assign in_w     = sync_q[SYNC_STAGES-1];
  assign rise     = in_w & ~prev_q;
  assign fall     = ~in_w & prev_q;
  assign edge_hit = (iboth_q & (rise | fall)) |
                    (~iboth_q & ipol_q & rise) |
                    (~iboth_q & ~ipol_q & fall);
  assign level    = ~(in_w ^ ipol_q);
  assign w1c      = (wr_en && (idx == R_ISTAT)) ? wmask : '0;

  // Until the synchroniser has flushed its reset contents, hold ISTAT so that
  // neither stale edges nor stale levels become visible. A new edge is OR'd
  // after the clear so it wins over a same-cycle write-one-to-clear.
  always_comb begin
    istat_d = istat_q;
    if (warm_done) begin
      istat_d = (itype_q & ((istat_q & ~w1c) | edge_hit)) | (~itype_q & level);
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      dir_q   <= '0;
      out_q   <= '0;
      ie_q    <= '0;
      itype_q <= '0;
      ipol_q  <= '0;
      iboth_q <= '0;
      istat_q <= '0;
      prev_q  <= '0;
      sync_q  <= '0;
      warm_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
      end
      prev_q  <= in_w;
      if (!warm_done) begin
        warm_q <= warm_q + WARM_W'(1);
      end
      istat_q <= istat_d;
      irq_q   <= |(istat_q & ie_q);
      if (wr_en) begin
        case (idx)
          R_DIR:    dir_q   <= (dir_q   & ~strb_mask) | wmask;
          R_OUT:    out_q   <= (out_q   & ~strb_mask) | wmask;
          R_IE:     ie_q    <= (ie_q    & ~strb_mask) | wmask;
          R_ITYPE:  itype_q <= (itype_q & ~strb_mask) | wmask;
          R_IPOL:   ipol_q  <= (ipol_q  & ~strb_mask) | wmask;
          R_IBOTH:  iboth_q <= (iboth_q & ~strb_mask) | wmask;
          R_OUTSET: out_q   <= out_q | wmask;
          R_OUTCLR: out_q   <= out_q & ~wmask;
          default:  ;
        endcase
      end
    end
  end

  // Read mux: data only during a read access phase, zero otherwise
  always_comb begin
    PRDATA = '0;
    if (access && !PWRITE) begin
      case (idx)
        R_DIR:   PRDATA = dir_q;
        R_OUT:   PRDATA = out_q;
        R_IN:    PRDATA = in_w;
        R_IE:    PRDATA = ie_q;
        R_ITYPE: PRDATA = itype_q;
        R_IPOL:  PRDATA = ipol_q;
        R_IBOTH: PRDATA = iboth_q;
        R_ISTAT: PRDATA = istat_q;
        default: PRDATA = '0;
      endcase
    end
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = err;
  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;
  assign irq_o   = irq_q;

endmodule
`default_nettype wire
